axis_frame_source: RTL and testbench

- Stream-master transmitter: the source end of the valid/ready/last stream interface that the register stage consumes.
- Local write port fills an internal circular buffer with Q2.6 samples.
- On `start`, emits exactly one frame of `frame_len` beats on `data_out`/`tvalid_out`/`tlast_out`, honouring backpressure on `tready_in`.
- Replaces ad-hoc bench-side sample sourcing with synthesizable frame generation.

---
 rtl/axis_frame_source.sv | 142 ++++++++++++++
 tb/tb_axis_frame_source.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_source.sv
// axis_frame_source: buffers Q2.6 samples written on a local port and, on
// request, emits exactly one frame of frame_len beats on a valid/ready/last
// stream.
//
// Stream handshake: a beat transfers on a rising edge where tvalid_out and
// tready_in are both high. Once tvalid_out rises it stays high, with data_out
// and tlast_out stable, until that beat transfers. tlast_out marks the final
// beat of the frame.
module axis_frame_source #(
  parameter int data_width = 8,
  parameter int depth = 16,
  parameter int frame_len = 11,
  localparam int addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  wr_full,
  output logic                  overflow,
  input  logic                  start,
  output logic                  start_err,
  input  logic                  tready_in,
  output logic [data_width-1:0] data_out,
  output logic                  tvalid_out,
  output logic                  tlast_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic [addr_width:0]   level,
  output logic                  dbg_state    // 0 = IDLE, 1 = SEND
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [addr_width:0] c_depth     = (addr_width+1)'(depth);
  localparam logic [addr_width:0] c_frame_len = (addr_width+1)'(frame_len);
  localparam logic [addr_width:0] c_last_beat = (addr_width+1)'(frame_len - 1);
  localparam logic [addr_width-1:0] c_ptr_one = addr_width'(1);
  localparam logic [addr_width:0]   c_cnt_one = (addr_width+1)'(1);

  state_t                r_state;
  state_t                w_state_next;
  logic [data_width-1:0] r_mem [depth];
  logic [addr_width-1:0] r_wr_ptr;
  logic [addr_width-1:0] r_rd_ptr;
  logic [addr_width:0]   r_level;
  logic [addr_width:0]   r_beat_cnt;
  logic                  r_overflow;
  logic                  r_start_err;
  logic                  r_frame_done;

  logic w_wr_accept;
  logic w_send;
  logic w_pop;
  logic w_last;
  logic w_start_ok;
  logic w_start_bad;

  // A write at full is dropped even if a pop happens in the same cycle: the
  // slot under rd_ptr is still counted in level until the pop lands.
  assign w_wr_accept = wr_en && (r_level != c_depth);
  assign w_send      = (r_state == SEND);
  assign w_pop       = w_send && tready_in;
  assign w_last      = w_send && (r_beat_cnt == c_last_beat);
  // Only occupancy already registered at the start cycle counts.
  assign w_start_ok  = (r_state == IDLE) && start && (r_level >= c_frame_len);
  assign w_start_bad = (r_state == IDLE) && start && (r_level <  c_frame_len);

  assign tvalid_out = w_send;
  assign busy       = w_send;
  assign tlast_out  = w_last;
  assign data_out   = w_send ? r_mem[r_rd_ptr] : '0;
  assign wr_full    = (r_level == c_depth);
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign start_err  = r_start_err;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

  // Sample storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= wr_data;
  end

  // Write/read pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)       r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_wr_accept, w_pop})
        2'b10:   r_level <= r_level + c_cnt_one;
        2'b01:   r_level <= r_level - c_cnt_one;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_start_err  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (wr_en && !w_wr_accept) r_overflow <= 1'b1;
      r_start_err  <= w_start_bad;
      r_frame_done <= w_pop && w_last;
    end
  end

  // Beat counter within the current frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if (w_start_ok) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + c_cnt_one;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = SEND;
      SEND:    if (w_pop && w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Bench for axis_frame_source: directed frames with a reference model of the
// buffer (expected-sample queue), occupancy, FSM and status pulses.
module tb_axis_frame_source;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int FLEN  = 11;
  localparam int AW    = 4;

  // Clock/reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          tready_in = 1'b1;
  logic          wr_full, overflow, start_err, tvalid_out, tlast_out;
  logic          busy, frame_done, dbg_state;
  logic [DW-1:0] data_out;
  logic [AW:0]   level;

  axis_frame_source #(.data_width(DW), .depth(DEPTH), .frame_len(FLEN)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .overflow(overflow), .start(start),
    .start_err(start_err), .tready_in(tready_in), .data_out(data_out),
    .tvalid_out(tvalid_out), .tlast_out(tlast_out), .busy(busy),
    .frame_done(frame_done), .level(level), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard / reference model
  logic [DW-1:0] exp_q[$];
  int m_level = 0;
  int m_beat = 0;
  bit m_busy = 0;
  bit m_overflow = 0;
  bit m_fd_pend = 0;
  bit m_serr_pend = 0;

  // Outputs sampled on the falling edge; model advanced with the inputs that
  // the next rising edge will see.
  always @(negedge clk) begin
    if (reset) begin
      check_eq("rst_tvalid", tvalid_out, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_flags", {overflow, wr_full, start_err, frame_done, tlast_out}, 0);
      check_eq("rst_data", data_out, 0);
      exp_q.delete();
      m_level = 0; m_beat = 0; m_busy = 0; m_overflow = 0;
      m_fd_pend = 0; m_serr_pend = 0;
    end else begin : mon_run
      bit pop;
      bit acc;
      check_eq("tvalid", tvalid_out, m_busy);
      check_eq("busy", busy, m_busy);
      check_eq("dbg_state", dbg_state, m_busy);
      check_eq("level", level, m_level);
      check_eq("wr_full", wr_full, m_level == DEPTH);
      check_eq("overflow", overflow, m_overflow);
      check_eq("frame_done", frame_done, m_fd_pend);
      check_eq("start_err", start_err, m_serr_pend);
      if (m_busy) begin
        check_eq("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("data", data_out, exp_q[0]);
        check_eq("tlast", tlast_out, m_beat == FLEN - 1);
      end else begin
        check_eq("idle_data", data_out, 0);
        check_eq("idle_tlast", tlast_out, 0);
      end
      pop = m_busy && tready_in;
      acc = wr_en && (m_level < DEPTH);
      m_fd_pend   = pop && (m_beat == FLEN - 1);
      m_serr_pend = !m_busy && start && (m_level < FLEN);
      if (wr_en && m_level == DEPTH) m_overflow = 1;
      if (m_busy) begin
        if (pop) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (m_beat == FLEN - 1) begin
            m_busy = 0;
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end
      end else if (start && m_level >= FLEN) begin
        m_busy = 1;
        m_beat = 0;
      end
      m_level = m_level + int'(acc) - int'(pop);
      if (acc) exp_q.push_back(wr_data);
    end
  end

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(base + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input bit with_wr);
    start = 1'b1;
    if (with_wr) begin
      wr_en = 1'b1;
      wr_data = 8'h80;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  // Runs one frame; stalls on beats 3 and 7 for two cycles each when asked.
  task automatic run_frame(input bit stall, input bit wr_alt, input int exp_cycles);
    int c = 0;
    while (tvalid_out && c < 64) begin
      tready_in = !(stall && (c == 2 || c == 3 || c == 8 || c == 9));
      if (wr_alt) begin
        wr_en = 1'b1;
        wr_data = c[0] ? 8'h80 : 8'hFF;
      end
      tick();
      c++;
    end
    tready_in = 1'b1;
    wr_en = 1'b0;
    check_eq("frame_cycles", c, exp_cycles);
    tick();
  endtask

  initial begin
    #1;
    check_eq("init_tvalid", tvalid_out, 0);
    check_eq("init_level", level, 0);
    check_eq("init_flags", {overflow, wr_full, start_err, frame_done, busy}, 0);
    tick();
    tick();
    reset = 1'b0;

    // Basic frame
    write_n(FLEN, 1);
    pulse_start(0);
    run_frame(0, 0, FLEN);

    // Backpressure
    write_n(FLEN, 1);
    pulse_start(0);
    run_frame(1, 0, FLEN + 4);

    // Insufficient data, then topped up
    write_n(FLEN - 1, 1);
    pulse_start(0);
    tick();
    tick();
    check_eq("short_no_valid", tvalid_out, 0);
    check_eq("short_level", level, FLEN - 1);
    write_n(1, FLEN);
    pulse_start(0);
    run_frame(0, 0, FLEN);

    // Full / overflow
    do_reset();
    write_n(DEPTH + 1, 1);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_full", wr_full, 1);
    pulse_start(0);
    run_frame(0, 0, FLEN);
    pulse_start(0);
    check_eq("ovf_start_err", start_err, 1);
    tick();
    check_eq("ovf_level", level, DEPTH - FLEN);

    // Wrap with writes during the frame
    do_reset();
    write_n(FLEN, 1);
    pulse_start(0);
    run_frame(0, 0, FLEN);
    write_n(FLEN, 8'h21);
    pulse_start(1);
    run_frame(0, 1, FLEN);
    check_eq("wrap_level", level, FLEN + 1);
    pulse_start(0);
    run_frame(0, 0, FLEN);

    // Reset mid-frame
    do_reset();
    write_n(FLEN, 1);
    pulse_start(0);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_tvalid", tvalid_out, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_level", level, 0);
    check_eq("midrst_done", frame_done, 0);
    tick();
    tick();
    reset = 1'b0;
    write_n(FLEN, 8'h41);
    pulse_start(0);
    run_frame(0, 0, FLEN);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
